// File: rtl/multi_press_tracker_pkg.sv
// Shared definitions for the multi-channel button press tracker.
//   press_state_e : per-channel press FSM encoding (IDLE, PRESS, LONG)
//   sat_max()     : all-ones value of a counter of the given width
package multi_press_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } press_state_e;

    // Saturation ceiling of an unsigned counter; width 32 wraps to all ones.
    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/multi_press_tracker_press_channel.sv
// One button channel: 2-flop synchroniser, debounce, press FSM, saturating
// duration counter, long-press detection and release latch.
// Optional build macro: MULTI_PRESS_AUTO_REPEAT_EN (auto-repeat in LONG).
// Ports:
//   clk, rst       : clock, async active-high reset
//   tick           : timebase strobe advancing press_time
//   btn            : raw asynchronous button level
//   is_pressing    : debounced level
//   press_time     : live press duration (ticks, saturating)
//   long_pulse     : one-cycle strobe when press_time reaches LONG_TH
//   release_pulse  : one-cycle strobe on debounced release
//   release_time   : duration latched at release
//   release_long   : long/short flag latched at release
//   repeat_pulse   : auto-repeat strobe (0 unless the macro is defined)
module multi_press_tracker_press_channel #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned LONG_TH       = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn,
    output logic             is_pressing,
    output logic [CNT_W-1:0] press_time,
    output logic             long_pulse,
    output logic             release_pulse,
    output logic [CNT_W-1:0] release_time,
    output logic             release_long,
    output logic             repeat_pulse
);
    import multi_press_tracker_pkg::*;

    localparam int unsigned      DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PT_MAX   = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] PT_LONG  = CNT_W'(LONG_TH);

    // Elaboration-time parameter sanity checks.
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end
    if (LONG_TH < 1 || LONG_TH > sat_max(CNT_W)) begin : g_bad_long
        $error("LONG_TH must lie in 1..2^CNT_W-1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("REPEAT_PERIOD must be at least 1");
    end

    logic             sync_meta;
    logic             sync_q;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             deb_flip_c;
    logic             rise_c;
    logic             fall_c;

    press_state_e     state;
    press_state_e     state_d;
    logic [CNT_W-1:0] press_time_d;
    logic [CNT_W-1:0] pt_inc_c;
    logic [CNT_W-1:0] release_time_d;
    logic             release_long_d;
    logic             long_pulse_d;
    logic             release_pulse_d;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive disagreeing cycles.
    always_comb begin
        deb_cnt_d  = '0;
        deb_flip_c = 1'b0;
        if (sync_q != is_pressing) begin
            if (deb_cnt == DEB_LAST) begin
                deb_flip_c = 1'b1;
            end else begin
                deb_cnt_d = deb_cnt + DEB_W'(1);
            end
        end
    end

    assign rise_c   = deb_flip_c & ~is_pressing;
    assign fall_c   = deb_flip_c & is_pressing;
    assign pt_inc_c = (press_time == PT_MAX) ? press_time : press_time + CNT_W'(1);

    // Press FSM next state and registered outputs; a fall outranks a same-cycle tick.
    always_comb begin
        state_d         = state;
        press_time_d    = press_time;
        release_time_d  = release_time;
        release_long_d  = release_long;
        long_pulse_d    = 1'b0;
        release_pulse_d = 1'b0;
        case (state)
            IDLE: begin
                if (rise_c) begin
                    state_d      = PRESS;
                    press_time_d = '0;
                end
            end
            PRESS, LONG: begin
                if (fall_c) begin
                    state_d         = IDLE;
                    release_time_d  = press_time;
                    release_long_d  = (state == LONG);
                    press_time_d    = '0;
                    release_pulse_d = 1'b1;
                end else if (tick) begin
                    press_time_d = pt_inc_c;
                    if (state == PRESS && pt_inc_c == PT_LONG) begin
                        state_d      = LONG;
                        long_pulse_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                press_time_d = '0;
            end
        endcase
    end

    // State register plus debounce and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            is_pressing   <= 1'b0;
            deb_cnt       <= '0;
            press_time    <= '0;
            release_time  <= '0;
            release_long  <= 1'b0;
            long_pulse    <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            is_pressing   <= is_pressing ^ deb_flip_c;
            deb_cnt       <= deb_cnt_d;
            press_time    <= press_time_d;
            release_time  <= release_time_d;
            release_long  <= release_long_d;
            long_pulse    <= long_pulse_d;
            release_pulse <= release_pulse_d;
        end
    end

`ifdef MULTI_PRESS_AUTO_REPEAT_EN
    localparam int unsigned      REP_W    = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_d;
    logic             repeat_pulse_d;

    // Repeat counter runs only while LONG persists; entry to LONG restarts it.
    always_comb begin
        rep_cnt_d      = rep_cnt;
        repeat_pulse_d = 1'b0;
        if (state != LONG) begin
            rep_cnt_d = '0;
        end else if (!fall_c && tick) begin
            if (rep_cnt == REP_LAST) begin
                rep_cnt_d      = '0;
                repeat_pulse_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_cnt_d;
            repeat_pulse <= repeat_pulse_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_press_tracker.sv
// Multi-channel button press tracker: N_CH independent debounced channels
// with press timing, long-press detection and release events.
// Optional build macro: MULTI_PRESS_AUTO_REPEAT_EN (auto-repeat pulses in LONG).
// Ports:
//   clk, rst       : clock, async active-high reset
//   tick           : shared timebase strobe
//   btn            : raw button levels, one bit per channel
//   is_pressing    : debounced levels
//   press_time     : live durations, channel i at [i*CNT_W +: CNT_W]
//   long_pulse     : long-press strobes
//   release_pulse  : release strobes
//   release_time   : durations latched at release, same packing as press_time
//   release_long   : long/short flags latched at release
//   repeat_pulse   : auto-repeat strobes (0 unless the macro is defined)
module multi_press_tracker #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned LONG_TH       = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [N_CH-1:0]       btn,
    output logic [N_CH-1:0]       is_pressing,
    output logic [N_CH*CNT_W-1:0] press_time,
    output logic [N_CH-1:0]       long_pulse,
    output logic [N_CH-1:0]       release_pulse,
    output logic [N_CH*CNT_W-1:0] release_time,
    output logic [N_CH-1:0]       release_long,
    output logic [N_CH-1:0]       repeat_pulse
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("N_CH must lie in 1..16");
    end

    // One tracker per channel, outputs packed into the flat buses.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        multi_press_tracker_press_channel #(
            .CNT_W         (CNT_W),
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_TH       (LONG_TH),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .btn           (btn[i]),
            .is_pressing   (is_pressing[i]),
            .press_time    (press_time[i*CNT_W +: CNT_W]),
            .long_pulse    (long_pulse[i]),
            .release_pulse (release_pulse[i]),
            .release_time  (release_time[i*CNT_W +: CNT_W]),
            .release_long  (release_long[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule
